sargantana_icache_tag_ctrl: RTL and testbench

Initiator side of the I-cache tag array: accepts lookup requests from the fetch pipeline, drives the per-way tag/valid memory (request, write enable, valid bit, flush, address, tag), compares the returned per-way tags and valid bits, and reports hit/way or miss. On a miss it selects a victim way, waits for the refill, then writes the new tag with its valid bit set. It sits between the fetch stage and the tag-memory instance inside the I-cache top level.

---
 rtl/sargantana_icache_pkg.sv | 26 ++
 rtl/sargantana_icache_repl_ptr.sv | 42 ++++
 rtl/sargantana_icache_tag_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sargantana_icache_tag_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared I-cache definitions: default geometry, tag-controller FSM states and
// the tag-memory request bundle driven toward the tag array.
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAY = 4;
    localparam int ICACHE_TAG_W = 20;
    localparam int ICACHE_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_REFILL    = 2'd3
    } tag_state_e;

    // Field widths follow the package geometry above.
    typedef struct packed {
        logic [ICACHE_N_WAY-1:0] req;
        logic                    we;
        logic                    vbit;
        logic                    flush;
        logic [ICACHE_IDX_W-1:0] addr;
        logic [ICACHE_TAG_W-1:0] data;
    } tmem_req_t;

endpackage

// File: rtl/sargantana_icache_repl_ptr.sv
// Victim pointer for full sets. Round-robin counter by default; an 8-bit
// Fibonacci LFSR when SARGANTANA_ICACHE_LFSR_REPL_EN is defined.
module sargantana_icache_repl_ptr
    import sargantana_icache_pkg::*;
#(
    parameter int N_WAY = ICACHE_N_WAY,
    parameter int PTR_W = $clog2(N_WAY)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             advance_i,
    output logic [PTR_W-1:0] ptr_o
);

`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
    logic [7:0] r_lfsr;

    // Taps 8,6,5,4 map to bits 7,5,4,3.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lfsr <= 8'h01;
        end else if (advance_i) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign ptr_o = r_lfsr[PTR_W-1:0];
`else
    logic [PTR_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (advance_i) begin
            r_cnt <= (r_cnt == PTR_W'(N_WAY - 1)) ? '0 : r_cnt + PTR_W'(1);
        end
    end

    assign ptr_o = r_cnt;
`endif

endmodule

// File: rtl/sargantana_icache_tag_ctrl.sv
// I-cache tag controller: issues tag reads, compares ways, reports hit/miss and
// installs the refilled tag. Replacement policy selected by SARGANTANA_ICACHE_LFSR_REPL_EN.
module sargantana_icache_tag_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int N_WAY = ICACHE_N_WAY,
    parameter int TAG_W = ICACHE_TAG_W,
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [IDX_W-1:0]       lkp_idx_i,
    input  logic [TAG_W-1:0]       lkp_tag_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_hit_o,
    output logic [N_WAY-1:0]       rsp_way_o,
    input  logic                   refill_valid_i,
    output logic [N_WAY-1:0]       tmem_req_o,
    output logic                   tmem_we_o,
    output logic                   tmem_vbit_o,
    output logic                   tmem_flush_o,
    output logic [TAG_W-1:0]       tmem_data_o,
    output logic [IDX_W-1:0]       tmem_addr_o,
    input  logic [N_WAY*TAG_W-1:0] tmem_tag_way_i,
    input  logic [N_WAY-1:0]       tmem_vbit_i,
    output logic [1:0]             dbg_state_o
);

    localparam int PTR_W = $clog2(N_WAY);

    // Handshake: a lookup transfers on a rising clk_i edge where lkp_valid_i
    // and lkp_ready_o are both high; rsp_valid_o is a one-cycle pulse with no
    // back-pressure.

    tag_state_e       r_state;
    tag_state_e       w_state_nxt;
    logic             r_rst_done;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [N_WAY-1:0] r_victim;
    logic             r_rsp_valid;
    logic             r_rsp_hit;
    logic [N_WAY-1:0] r_rsp_way;
    logic             r_flush;

    logic [N_WAY-1:0] w_hit_vec;
    logic [N_WAY-1:0] w_hit_way;
    logic [N_WAY-1:0] w_free_way;
    logic [N_WAY-1:0] w_victim;
    logic             w_hit;
    logic             w_accept;
    logic             w_refill_wr;
    logic [PTR_W-1:0] w_ptr;
    tmem_req_t        w_tmem;

    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < N_WAY; w++) begin
            w_hit_vec[w] = tmem_vbit_i[w] & (tmem_tag_way_i[w*TAG_W +: TAG_W] == r_tag);
        end
    end

    // x & (~x + 1) isolates the lowest set bit; applied to ~vbit it finds the
    // lowest invalid way and yields zero when every way is valid.
    assign w_hit       = |w_hit_vec;
    assign w_hit_way   = w_hit_vec & (~w_hit_vec + N_WAY'(1));
    assign w_free_way  = ~tmem_vbit_i & (tmem_vbit_i + N_WAY'(1));
    assign w_victim    = (|w_free_way) ? w_free_way : (N_WAY'(1) << w_ptr);
    assign w_refill_wr = (r_state == ST_REFILL) && !flush_i;

    sargantana_icache_repl_ptr #(
        .N_WAY (N_WAY),
        .PTR_W (PTR_W)
    ) u_repl_ptr (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .advance_i (w_refill_wr),
        .ptr_o     (w_ptr)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP:    w_state_nxt = w_hit ? (w_accept ? ST_LOOKUP : ST_IDLE) : ST_MISS_WAIT;
            ST_MISS_WAIT: if (refill_valid_i) w_state_nxt = ST_REFILL;
            ST_REFILL:    w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Flush suppresses both a new accept and a pending tag write this cycle.
    always_comb begin
        lkp_ready_o = 1'b0;
        w_tmem      = '0;
        case (r_state)
            ST_IDLE:   lkp_ready_o = r_rst_done;
            ST_LOOKUP: lkp_ready_o = r_rst_done & w_hit;
            ST_REFILL: begin
                w_tmem.req  = r_victim;
                w_tmem.we   = 1'b1;
                w_tmem.vbit = 1'b1;
                w_tmem.addr = r_idx;
                w_tmem.data = r_tag;
            end
            default: ;
        endcase
        if (flush_i) begin
            lkp_ready_o = 1'b0;
            w_tmem      = '0;
        end
        w_accept = lkp_valid_i & lkp_ready_o;
        if (w_accept) begin
            w_tmem.req  = '1;
            w_tmem.addr = lkp_idx_i;
        end
        w_tmem.flush = r_flush;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rst_done  <= 1'b0;
            r_idx       <= '0;
            r_tag       <= '0;
            r_victim    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_rst_done  <= 1'b1;
            r_flush     <= flush_i;
            r_rsp_valid <= (r_state == ST_LOOKUP) && !flush_i;
            if (w_accept) begin
                r_idx <= lkp_idx_i;
                r_tag <= lkp_tag_i;
            end
            if ((r_state == ST_LOOKUP) && !flush_i) begin
                r_rsp_hit <= w_hit;
                r_rsp_way <= w_hit ? w_hit_way : w_victim;
                if (!w_hit) begin
                    r_victim <= w_victim;
                end
            end
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_hit_o    = r_rsp_hit;
    assign rsp_way_o    = r_rsp_way;
    assign tmem_req_o   = w_tmem.req;
    assign tmem_we_o    = w_tmem.we;
    assign tmem_vbit_o  = w_tmem.vbit;
    assign tmem_flush_o = w_tmem.flush;
    assign tmem_data_o  = w_tmem.data;
    assign tmem_addr_o  = w_tmem.addr;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Directed bench for the I-cache tag controller: response and tag-write
// scoreboards fed by driver tasks, popped by negedge monitors.
module tb_sargantana_icache_tag_ctrl;
  import sargantana_icache_pkg::*;

  localparam int N_WAY = 4;
  localparam int TAG_W = 20;
  localparam int IDX_W = 6;
  localparam int RSP_W = 32 + 1 + N_WAY;
  localparam int WR_W  = 32 + N_WAY + IDX_W + TAG_W;

  logic                   clk_i;
  logic                   rstn_i;
  logic                   flush_i;
  logic                   lkp_valid_i;
  logic                   lkp_ready_o;
  logic [IDX_W-1:0]       lkp_idx_i;
  logic [TAG_W-1:0]       lkp_tag_i;
  logic                   rsp_valid_o;
  logic                   rsp_hit_o;
  logic [N_WAY-1:0]       rsp_way_o;
  logic                   refill_valid_i;
  logic [N_WAY-1:0]       tmem_req_o;
  logic                   tmem_we_o;
  logic                   tmem_vbit_o;
  logic                   tmem_flush_o;
  logic [TAG_W-1:0]       tmem_data_o;
  logic [IDX_W-1:0]       tmem_addr_o;
  logic [N_WAY*TAG_W-1:0] tmem_tag_way_i;
  logic [N_WAY-1:0]       tmem_vbit_i;
  logic [1:0]             dbg_state_o;

  logic [RSP_W-1:0] exp_q[$];
  logic [WR_W-1:0]  wr_q[$];
  logic [RSP_W-1:0] rsp_e;
  logic [WR_W-1:0]  wr_e;
  logic [31:0]      cyc = 32'd0;
  int               n_cmp = 0;
  int               n_bad = 0;

  sargantana_icache_tag_ctrl dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .flush_i        (flush_i),
    .lkp_valid_i    (lkp_valid_i),
    .lkp_ready_o    (lkp_ready_o),
    .lkp_idx_i      (lkp_idx_i),
    .lkp_tag_i      (lkp_tag_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_hit_o      (rsp_hit_o),
    .rsp_way_o      (rsp_way_o),
    .refill_valid_i (refill_valid_i),
    .tmem_req_o     (tmem_req_o),
    .tmem_we_o      (tmem_we_o),
    .tmem_vbit_o    (tmem_vbit_o),
    .tmem_flush_o   (tmem_flush_o),
    .tmem_data_o    (tmem_data_o),
    .tmem_addr_o    (tmem_addr_o),
    .tmem_tag_way_i (tmem_tag_way_i),
    .tmem_vbit_i    (tmem_vbit_i),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_view(input logic [3:0] v, input logic [19:0] t0, input logic [19:0] t1,
                          input logic [19:0] t2, input logic [19:0] t3);
    tmem_vbit_i    = v;
    tmem_tag_way_i = {t3, t2, t1, t0};
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic lookup(input logic [5:0] idx, input logic [19:0] tag,
                        input logic hit, input logic [3:0] way);
    int waits = 0;
    lkp_valid_i = 1'b1;
    lkp_idx_i   = idx;
    lkp_tag_i   = tag;
    @(negedge clk_i);
    while (!lkp_ready_o && waits < 20) begin
      waits++;
      @(negedge clk_i);
    end
    check("lkp_ready_wait", 32'(waits), 32'd0);
    if (lkp_ready_o) begin
      check("rd_req", 32'(tmem_req_o), 32'hF);
      check("rd_addr", 32'(tmem_addr_o), 32'(idx));
      check("rd_we", 32'(tmem_we_o), 32'd0);
      exp_q.push_back({cyc + 32'd2, hit, way});
    end
    @(posedge clk_i);
    #1;
    lkp_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 20);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic refill(input logic [3:0] way, input logic [5:0] idx, input logic [19:0] tag);
    refill_valid_i = 1'b1;
    @(negedge clk_i);
    check("miss_wait_state", 32'(dbg_state_o), 32'(ST_MISS_WAIT));
    wr_q.push_back({cyc + 32'd1, way, idx, tag});
    @(posedge clk_i);
    #1;
    refill_valid_i = 1'b0;
    tick();
  endtask

  task automatic miss_refill(input logic [5:0] idx, input logic [19:0] tag, input logic [3:0] way);
    lookup(idx, tag, 1'b0, way);
    wait_rsp();
    refill(way, idx, tag);
  endtask

  // scoreboard monitors
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1 && rsp_valid_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got hit=%0b way=%b at cyc %0d, expected no response",
                 rsp_hit_o, rsp_way_o, cyc);
      end else begin
        rsp_e = exp_q.pop_front();
        if ({cyc, rsp_hit_o, rsp_way_o} !== rsp_e) begin
          n_bad++;
          $display("FAIL rsp: got cyc=%0d hit=%0b way=%b, expected cyc=%0d hit=%0b way=%b",
                   cyc, rsp_hit_o, rsp_way_o, rsp_e[36:5], rsp_e[4], rsp_e[3:0]);
        end
      end
    end
    if (rstn_i === 1'b1 && tmem_we_o === 1'b1) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got write way=%b addr=%0d at cyc %0d, expected none",
                 tmem_req_o, tmem_addr_o, cyc);
      end else begin
        wr_e = wr_q.pop_front();
        if ({cyc, tmem_req_o, tmem_addr_o, tmem_data_o} !== wr_e) begin
          n_bad++;
          $display("FAIL wr: got cyc=%0d way=%b addr=%0d data=%0h, expected cyc=%0d way=%b addr=%0d data=%0h",
                   cyc, tmem_req_o, tmem_addr_o, tmem_data_o,
                   wr_e[61:30], wr_e[29:26], wr_e[25:20], wr_e[19:0]);
        end
      end
      n_cmp++;
      if (tmem_vbit_o !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_vbit: got %0b expected 1", tmem_vbit_o);
      end
    end
  end

  initial begin
    rstn_i         = 1'b0;
    flush_i        = 1'b0;
    lkp_valid_i    = 1'b0;
    lkp_idx_i      = '0;
    lkp_tag_i      = '0;
    refill_valid_i = 1'b0;
    set_view(4'h0, 20'h0, 20'h0, 20'h0, 20'h0);

    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(lkp_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_way", 32'(rsp_way_o), 32'd0);
    check("rst_req", 32'(tmem_req_o), 32'd0);
    check("rst_we", 32'(tmem_we_o), 32'd0);
    check("rst_flush", 32'(tmem_flush_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rstn_i = 1'b1;
    tick();
    check("ready_after_rst", 32'(lkp_ready_o), 32'd1);

    // round-robin victims on full sets
    set_view(4'hF, 20'h00001, 20'h00002, 20'h00003, 20'h00004);
    miss_refill(6'd10, 20'hAAAAA, 4'b0001);
    miss_refill(6'd10, 20'hBBBBB, 4'b0010);
    miss_refill(6'd10, 20'hCCCCC, 4'b0100);

    // cold set: lowest invalid way
    set_view(4'h0, 20'h0, 20'h0, 20'h0, 20'h0);
    miss_refill(6'd5, 20'h12345, 4'b0001);

    // pointer wrapped from 3 to 0
    set_view(4'hF, 20'h00001, 20'h00002, 20'h00003, 20'h00004);
    miss_refill(6'd7, 20'h77777, 4'b0001);

    // one invalid way beats the pointer
    set_view(4'b1011, 20'h00001, 20'h00002, 20'h00003, 20'h00004);
    miss_refill(6'd9, 20'h99999, 4'b0100);

    // single hit, then four back-to-back hits
    set_view(4'hF, 20'h11111, 20'h22222, 20'hABCDE, 20'h33333);
    lookup(6'd3, 20'hABCDE, 1'b1, 4'b0100);
    wait_rsp();
    lookup(6'd3, 20'hABCDE, 1'b1, 4'b0100);
    lookup(6'd3, 20'h11111, 1'b1, 4'b0001);
    lookup(6'd3, 20'h33333, 1'b1, 4'b1000);
    lookup(6'd3, 20'h22222, 1'b1, 4'b0010);
    wait_rsp();

    // invalid matching way ignored; duplicate valid match picks lowest
    set_view(4'b1101, 20'h11111, 20'h55555, 20'hABCDE, 20'h55555);
    lookup(6'd4, 20'h55555, 1'b1, 4'b1000);
    wait_rsp();
    set_view(4'hF, 20'h11111, 20'h55555, 20'hABCDE, 20'h55555);
    lookup(6'd4, 20'h55555, 1'b1, 4'b0010);
    wait_rsp();

    // flush in MISS_WAIT together with refill_valid_i
    set_view(4'hF, 20'h00001, 20'h00002, 20'h00003, 20'h00004);
    lookup(6'd12, 20'hDDDDD, 1'b0, 4'b0100);
    wait_rsp();
    flush_i        = 1'b1;
    refill_valid_i = 1'b1;
    @(negedge clk_i);
    check("flush_ready_low", 32'(lkp_ready_o), 32'd0);
    tick();
    flush_i        = 1'b0;
    refill_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_pulse", 32'(tmem_flush_o), 32'd1);
    check("flush_ready_back", 32'(lkp_ready_o), 32'd1);
    check("flush_state", 32'(dbg_state_o), 32'(ST_IDLE));
    tick();
    @(negedge clk_i);
    check("flush_pulse_end", 32'(tmem_flush_o), 32'd0);
    tick();

    // flush wins over a simultaneous lookup
    lkp_valid_i = 1'b1;
    lkp_idx_i   = 6'd1;
    lkp_tag_i   = 20'h00001;
    flush_i     = 1'b1;
    @(negedge clk_i);
    check("flush_lkp_ready", 32'(lkp_ready_o), 32'd0);
    check("flush_lkp_req", 32'(tmem_req_o), 32'd0);
    tick();
    lkp_valid_i = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk_i);
    check("flush_lkp_state", 32'(dbg_state_o), 32'(ST_IDLE));
    repeat (3) tick();

    // pointer was not advanced by the aborted refill
    miss_refill(6'd12, 20'hDDDDD, 4'b0100);

    // asynchronous reset in the middle of REFILL
    lookup(6'd20, 20'hEEEEE, 1'b0, 4'b1000);
    wait_rsp();
    refill_valid_i = 1'b1;
    tick();
    refill_valid_i = 1'b0;
    check("refill_state", 32'(dbg_state_o), 32'(ST_REFILL));
    check("refill_we", 32'(tmem_we_o), 32'd1);
    check("refill_req", 32'(tmem_req_o), 32'b1000);
    #1;
    rstn_i = 1'b0;
    #1;
    check("arst_we", 32'(tmem_we_o), 32'd0);
    check("arst_req", 32'(tmem_req_o), 32'd0);
    check("arst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check("arst_ready", 32'(lkp_ready_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    check("arst_ready_back", 32'(lkp_ready_o), 32'd1);
    miss_refill(6'd21, 20'hFFFFF, 4'b0001);

    repeat (3) tick();
    check("rsp_q_empty", 32'(exp_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
